// File: rtl/uart_gen2_pkg.sv
// Shared types and helpers for the gen2 UART transmit engine.
package uart_gen2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DE_LEAD = 3'd1,
    START   = 3'd2,
    DATA    = 3'd3,
    PARITY  = 3'd4,
    STOP    = 3'd5,
    DE_HOLD = 3'd6
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;
  localparam logic [1:0] PAR_MARK = 2'd3;

  localparam logic [3:0] LEN_MIN = 4'd5;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned max_len);
    logic [3:0] max4;
    max4 = 4'(max_len);
    if (len < LEN_MIN) begin
      clamp_len = LEN_MIN;
    end else if (len > max4) begin
      clamp_len = max4;
    end else begin
      clamp_len = len;
    end
  endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous FIFO with flush, registered occupancy/full and dropped-write pulse.
module uart_fifo_sync #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic [$clog2(DEPTH):0]   cnt_nx,
  output logic                     full,
  output logic                     wr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   cnt_r, cnt_nx_s;
  logic          full_r, wr_err_r, push_s, pop_s;

  // Flush overrides everything; a write while full is refused
  always_comb begin
    push_s   = wr_en && !full_r && !flush;
    pop_s    = rd_en && (cnt_r != '0) && !flush;
    cnt_nx_s = cnt_r;
    if (flush) begin
      cnt_nx_s = '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   cnt_nx_s = cnt_r + CNT_ONE;
        2'b01:   cnt_nx_s = cnt_r - CNT_ONE;
        default: cnt_nx_s = cnt_r;
      endcase
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  // Pointers and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      full_r   <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nx_s;
      full_r   <= (cnt_nx_s == FULL_CNT);
      wr_err_r <= wr_en && full_r && !flush;
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign cnt     = cnt_r;
  assign cnt_nx  = cnt_nx_s;
  assign full    = full_r;
  assign wr_err  = wr_err_r;

endmodule

// File: rtl/uart_tx_gen2.sv
// UART transmit engine: FIFO, per-frame shadowed config, CTS gating and RS-485 xDE lead/hold.
module uart_tx_gen2
  import uart_gen2_pkg::*;
#(
  parameter int pMaxLen    = 9,
  parameter int pFifoDepth = 16,
  parameter int pDivW      = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [pDivW-1:0]              Baud_Div,
  input  logic [3:0]                    Len,
  input  logic [1:0]                    Par,
  input  logic                          Stop2,
  input  logic                          Mode485,
  input  logic                          CTS_En,
  input  logic                          xCTS,
  input  logic                          Flush,
  input  logic                          Wr_En,
  input  logic [pMaxLen-1:0]            Wr_Data,
  input  logic [$clog2(pFifoDepth):0]   Thr,
  output logic [$clog2(pFifoDepth):0]   Cnt,
  output logic                          Full,
  output logic                          Wr_Err,
  output logic                          iTHE,
  output logic                          iTFE,
  output logic                          TxD,
  output logic                          xDE,
  output logic                          TxIdle
);

  localparam int CW = $clog2(pFifoDepth) + 1;
  localparam logic [pDivW-1:0] DIV_ONE = pDivW'(1'b1);

  tx_state_e          state_r;
  logic [pDivW-1:0]   baud_r, div_r;
  logic [3:0]         bit_cnt_r, len_cl_s;
  logic [pMaxLen-1:0] shift_r, fifo_rd_data_s;
  logic [1:0]         par_r;
  logic [CW-1:0]      fifo_cnt_s, fifo_cnt_nx_s;
  logic txd_r, xde_r, idle_r, the_r, tfe_r, par_bit_r, stop2_r;
  logic cts_meta_r, cts_sync_r;
  logic cts_ok_s, start_s, stop_end_s, pop_s, idle_nx_s, tick_s;

  function automatic logic calc_parity(input logic [pMaxLen-1:0] d, input logic [3:0] len,
                                       input logic [1:0] par);
    logic x;
    x = 1'b0;
    for (int i = 0; i < pMaxLen; i++) x = x ^ (d[i] & (4'(i) < len));
    case (par)
      PAR_ODD:  calc_parity = ~x;
      PAR_EVEN: calc_parity = x;
      PAR_MARK: calc_parity = 1'b1;
      default:  calc_parity = 1'b0;
    endcase
  endfunction

  uart_fifo_sync #(.W(pMaxLen), .DEPTH(pFifoDepth)) u_fifo (
    .clk(Clk), .rst_n(Rst), .flush(Flush), .wr_en(Wr_En), .wr_data(Wr_Data),
    .rd_en(pop_s), .rd_data(fifo_rd_data_s), .cnt(fifo_cnt_s), .cnt_nx(fifo_cnt_nx_s),
    .full(Full), .wr_err(Wr_Err)
  );

  assign len_cl_s = clamp_len(Len, pMaxLen);
  assign tick_s   = (baud_r == '0);

  // Frame-start decision and look-ahead of the idle flag for the status registers
  always_comb begin
    cts_ok_s   = !CTS_En || !cts_sync_r;
    start_s    = (fifo_cnt_s != '0) && cts_ok_s;
    stop_end_s = (state_r == STOP) && tick_s && (bit_cnt_r == 4'd1);
    pop_s      = start_s && ((state_r == IDLE) || stop_end_s);
    idle_nx_s  = ((state_r == IDLE) && !start_s) || ((state_r == DE_HOLD) && tick_s) ||
                 (stop_end_s && !start_s && !xde_r);
  end

  // xCTS synchroniser and registered FIFO status flags
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cts_meta_r <= 1'b1;
      cts_sync_r <= 1'b1;
      the_r      <= 1'b1;
      tfe_r      <= 1'b1;
    end else begin
      cts_meta_r <= xCTS;
      cts_sync_r <= cts_meta_r;
      the_r      <= (fifo_cnt_nx_s <= Thr);
      tfe_r      <= (fifo_cnt_nx_s == '0) && idle_nx_s;
    end
  end

  // Per-frame shadow of the line configuration, captured as the character is popped
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      div_r     <= '0;
      par_r     <= PAR_NONE;
      stop2_r   <= 1'b0;
      par_bit_r <= 1'b0;
    end else if (pop_s) begin
      div_r     <= Baud_Div;
      par_r     <= Par;
      stop2_r   <= Stop2;
      par_bit_r <= calc_parity(fifo_rd_data_s, len_cl_s, Par);
    end
  end

  // Transmit FSM; every state entry happens on a pop or a bit-end tick, which reloads the baud counter
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_cnt_r <= 4'd0;
      shift_r   <= '0;
      txd_r     <= 1'b1;
      xde_r     <= 1'b0;
      idle_r    <= 1'b1;
    end else begin
      idle_r <= idle_nx_s;
      if (pop_s)       baud_r <= Baud_Div;
      else if (tick_s) baud_r <= div_r;
      else             baud_r <= baud_r - DIV_ONE;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            shift_r   <= fifo_rd_data_s;
            bit_cnt_r <= len_cl_s;
            if (Mode485) begin
              state_r <= DE_LEAD;
              xde_r   <= 1'b1;
              txd_r   <= 1'b1;
            end else begin
              state_r <= START;
              txd_r   <= 1'b0;
            end
          end else begin
            txd_r <= 1'b1;
            xde_r <= 1'b0;
          end
        end
        DE_LEAD: if (tick_s) begin
          state_r <= START;
          txd_r   <= 1'b0;
        end
        START: if (tick_s) begin
          state_r <= DATA;
          txd_r   <= shift_r[0];
          shift_r <= {1'b0, shift_r[pMaxLen-1:1]};
        end
        DATA: if (tick_s) begin
          if (bit_cnt_r != 4'd1) begin
            txd_r     <= shift_r[0];
            shift_r   <= {1'b0, shift_r[pMaxLen-1:1]};
            bit_cnt_r <= bit_cnt_r - 4'd1;
          end else if (par_r != PAR_NONE) begin
            state_r <= PARITY;
            txd_r   <= par_bit_r;
          end else begin
            state_r   <= STOP;
            txd_r     <= 1'b1;
            bit_cnt_r <= stop2_r ? 4'd2 : 4'd1;
          end
        end
        PARITY: if (tick_s) begin
          state_r   <= STOP;
          txd_r     <= 1'b1;
          bit_cnt_r <= stop2_r ? 4'd2 : 4'd1;
        end
        STOP: if (tick_s) begin
          if (bit_cnt_r != 4'd1) begin
            bit_cnt_r <= bit_cnt_r - 4'd1;
          end else if (pop_s) begin
            shift_r   <= fifo_rd_data_s;
            bit_cnt_r <= len_cl_s;
            state_r   <= START;
            txd_r     <= 1'b0;
          end else if (xde_r) begin
            state_r <= DE_HOLD;
          end else begin
            state_r <= IDLE;
          end
        end
        DE_HOLD: if (tick_s) begin
          state_r <= IDLE;
          xde_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          txd_r   <= 1'b1;
          xde_r   <= 1'b0;
        end
      endcase
    end
  end

  assign Cnt    = fifo_cnt_s;
  assign iTHE   = the_r;
  assign iTFE   = tfe_r;
  assign TxD    = txd_r;
  assign xDE    = xde_r;
  assign TxIdle = idle_r;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Directed self-checking bench for uart_tx_gen2 (default parameters: 9-bit, depth 16).
module tb_uart_tx_gen2;

  logic        Clk, Rst;
  logic [15:0] Baud_Div;
  logic [3:0]  Len;
  logic [1:0]  Par;
  logic        Stop2, Mode485, CTS_En, xCTS, Flush, Wr_En;
  logic [8:0]  Wr_Data;
  logic [4:0]  Thr;
  logic [4:0]  Cnt;
  logic        Full, Wr_Err, iTHE, iTFE, TxD, xDE, TxIdle;

  int tests = 0;
  int fails = 0;

  uart_tx_gen2 dut (
    .Clk(Clk), .Rst(Rst), .Baud_Div(Baud_Div), .Len(Len), .Par(Par), .Stop2(Stop2),
    .Mode485(Mode485), .CTS_En(CTS_En), .xCTS(xCTS), .Flush(Flush), .Wr_En(Wr_En),
    .Wr_Data(Wr_Data), .Thr(Thr), .Cnt(Cnt), .Full(Full), .Wr_Err(Wr_Err), .iTHE(iTHE),
    .iTFE(iTFE), .TxD(TxD), .xDE(xDE), .TxIdle(TxIdle)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame without parity: start, len data bits LSB first, then stop
  function automatic logic exp_bit(input logic [8:0] d, input int len, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= len) return d[idx-1];
    return 1'b1;
  endfunction

  task automatic send(input logic [8:0] d);
    Wr_Data = d;
    Wr_En   = 1'b1;
    @(negedge Clk);
    Wr_En   = 1'b0;
  endtask

  // pat holds the expected line level per bit period, bit 0 = start bit
  task automatic check_frame(input string tag, input logic [15:0] pat, input int nbits, input int blen);
    for (int i = 0; i < nbits * blen; i++) begin
      chk(tag, {TxIdle, TxD}, {1'b0, pat[i / blen]});
      @(negedge Clk);
    end
    chk({tag, "_idle"}, {TxIdle, TxD}, 2'b11);
  endtask

  initial begin
    logic [2:0] e3;
    logic [1:0] e2;
    Rst = 1'b0; Baud_Div = 16'd3; Len = 4'd8; Par = 2'd0; Stop2 = 1'b0; Mode485 = 1'b0;
    CTS_En = 1'b0; xCTS = 1'b1; Flush = 1'b0; Wr_En = 1'b0; Wr_Data = 9'h000; Thr = 5'd4;
    repeat (2) @(negedge Clk);
    chk("rst_txd", TxD, 1'b1);
    chk("rst_xde", xDE, 1'b0);
    chk("rst_idle", TxIdle, 1'b1);
    chk("rst_tfe", iTFE, 1'b1);
    chk("rst_the", iTHE, 1'b1);
    chk("rst_full", Full, 1'b0);
    chk("rst_cnt", Cnt, 5'd0);
    chk("rst_werr", Wr_Err, 1'b0);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);

    // 8N1, 4 clocks per bit, 0x55
    send(9'h055);
    chk("t1_cnt", Cnt, 5'd1);
    @(negedge Clk);
    check_frame("t1_8n1", 16'h02AA, 10, 4);
    chk("t1_tfe", iTFE, 1'b1);

    // Parity, stop bits and length clamping, 2 clocks per bit
    Baud_Div = 16'd1; Len = 4'd7; Par = 2'd2;
    send(9'h003); @(negedge Clk);
    check_frame("t2_even", 16'h0206, 10, 2);
    Par = 2'd1;
    send(9'h003); @(negedge Clk);
    Par = 2'd0; Len = 4'd8;
    check_frame("t2_odd_shadow", 16'h0306, 10, 2);
    Par = 2'd3; Len = 4'd7;
    send(9'h003); @(negedge Clk);
    check_frame("t2_mark", 16'h0306, 10, 2);
    Par = 2'd2; Stop2 = 1'b1;
    send(9'h003); @(negedge Clk);
    check_frame("t2_stop2", 16'h0606, 11, 2);
    Par = 2'd0; Stop2 = 1'b0; Len = 4'd2;
    send(9'h01F); @(negedge Clk);
    check_frame("t2_len_lo", 16'h007E, 7, 2);
    Len = 4'd15;
    send(9'h1FF); @(negedge Clk);
    check_frame("t2_len_hi", 16'h07FE, 11, 2);

    // RS-485: lead, two back-to-back frames, hold
    Mode485 = 1'b1; Len = 4'd8; Baud_Div = 16'd1;
    send(9'h0A5);
    chk("t4_de_pre", xDE, 1'b0);
    send(9'h03C);
    chk("t4_cnt_wr_pop", Cnt, 5'd1);
    for (int i = 0; i < 45; i++) begin
      if (i < 2)       e3 = 3'b110;
      else if (i < 42) e3 = {1'b1, exp_bit((i < 22) ? 9'h0A5 : 9'h03C, 8, ((i - 2) / 2) % 10), 1'b0};
      else if (i < 44) e3 = 3'b110;
      else             e3 = 3'b011;
      chk("t4_485", {xDE, TxD, TxIdle}, e3);
      @(negedge Clk);
    end

    // Threshold and flush with CTS blocking transmission
    Mode485 = 1'b0; CTS_En = 1'b1; xCTS = 1'b1;
    repeat (3) @(negedge Clk);
    for (int k = 1; k <= 6; k++) begin
      send(9'(k));
      chk("t5_cnt", Cnt, 32'(k));
      chk("t5_the", iTHE, (k <= 4));
    end
    chk("t5_tfe_busy", iTFE, 1'b0);
    Flush = 1'b1; Wr_En = 1'b1; Wr_Data = 9'h1AA;
    @(negedge Clk);
    Flush = 1'b0; Wr_En = 1'b0;
    chk("t5_flush_cnt", Cnt, 5'd0);
    chk("t5_flush_the", iTHE, 1'b1);
    chk("t5_flush_tfe", iTFE, 1'b1);
    chk("t5_flush_werr", Wr_Err, 1'b0);
    @(negedge Clk);
    chk("t5_flush_wr_dropped", Cnt, 5'd0);
    chk("t5_no_tx", {TxIdle, TxD}, 2'b11);

    // Fill past full, then release CTS: 16 frames back-to-back at one clock per bit
    Baud_Div = 16'd0; Len = 4'd5; Par = 2'd0; Stop2 = 1'b0;
    for (int k = 0; k < 16; k++) send(9'(k));
    chk("t3_full", Full, 1'b1);
    chk("t3_cnt16", Cnt, 5'd16);
    chk("t3_werr_none", Wr_Err, 1'b0);
    send(9'h01F);
    chk("t3_werr_pulse", Wr_Err, 1'b1);
    @(negedge Clk);
    chk("t3_werr_end", Wr_Err, 1'b0);
    chk("t3_cnt_kept", Cnt, 5'd16);
    xCTS = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("t3_cts_lat", {TxIdle, TxD}, 2'b11);
    @(negedge Clk);
    for (int i = 0; i < 112; i++) begin
      e2 = {1'b0, exp_bit(9'(i / 7), 5, i % 7)};
      chk("t3_b2b", {TxIdle, TxD}, e2);
      @(negedge Clk);
    end
    chk("t3_idle", TxIdle, 1'b1);
    chk("t3_tfe", iTFE, 1'b1);
    chk("t3_cnt0", Cnt, 5'd0);

    // Asynchronous reset in the middle of a data bit
    xCTS = 1'b1; CTS_En = 1'b0; Mode485 = 1'b1; Baud_Div = 16'd3; Len = 4'd8;
    send(9'h000);
    send(9'h000);
    repeat (10) @(negedge Clk);
    chk("t6_pre", {xDE, TxD, TxIdle}, 3'b100);
    chk("t6_pre_cnt", Cnt, 5'd1);
    Rst = 1'b0;
    #1;
    chk("t6_async", {xDE, TxD, TxIdle}, 3'b011);
    chk("t6_async_cnt", Cnt, 5'd0);
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      chk("t6_quiet", {xDE, TxD, TxIdle, Cnt}, {3'b011, 5'd0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
